// File: rtl/zint_pkg.sv
// Shared types and helpers for the multi-source Z80 interrupt generator.
package zint_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        ACK,
        GAP
    } zint_state_t;

    localparam int ZINT_CW = 8;

    // Index of the lowest set bit; index 0 is the highest-priority source.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/zint_multi_zsync2.sv
// Two-flop synchroniser for raw Z80 strobes entering the fclk domain.
module zsync2 #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         fclk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/zint_multi.sv
// Multi-source Z80 interrupt generator: fixed priority, pending latches, IM2 vector.
// Define ZINT_VECTOR_EN to build the IM2 vector logic; otherwise vec/vec_oe are tied off (IM1).
module zint_multi
    import zint_pkg::*;
#(
    parameter int         NSRC      = 3,
    parameter int         PULSE_LEN = 32,
    parameter int         GAP_LEN   = 4,
    parameter logic [7:0] VEC_BASE  = 8'hFF
) (
    input  logic            fclk,
    input  logic            rst,
    input  logic            zpos,
    input  logic            iorq_n,
    input  logic            m1_n,
    input  logic [NSRC-1:0] src_req,
    input  logic [NSRC-1:0] src_en,
    input  logic [NSRC-1:0] clr,
    output logic [NSRC-1:0] pending,
    output logic            int_n,
    output logic [7:0]      vec,
    output logic            vec_oe
);

    localparam logic [ZINT_CW-1:0] PULSE_CNT = ZINT_CW'(PULSE_LEN);
    localparam logic [ZINT_CW-1:0] GAP_CNT   = ZINT_CW'(GAP_LEN);
    localparam logic [NSRC-1:0]    BIT0      = NSRC'(1);

    zint_state_t        state;
    logic [ZINT_CW-1:0] cnt;
    logic [1:0]         strb_sync;
    logic               ack;
    logic               ack_q;
    logic               ack_rise;
    logic               ack_take;
    logic [2:0]         sel_nxt;
    logic [NSRC-1:0]    ack_clr;
    logic [NSRC-1:0]    pend_nxt;

    zsync2 #(
        .W       (2),
        .RST_VAL (2'b11)
    ) u_sync (
        .fclk (fclk),
        .rst  (rst),
        .d    ({iorq_n, m1_n}),
        .q    (strb_sync)
    );

    assign ack      = ~strb_sync[1] & ~strb_sync[0];
    assign ack_rise = ack & ~ack_q;
    assign sel_nxt  = lowest_set(8'(pending));
    assign ack_take = (state == ASSERT) && ack_rise && (|pending);
    assign ack_clr  = ack_take ? (BIT0 << sel_nxt) : '0;
    // A request in the same cycle as any clear source keeps the bit set.
    assign pend_nxt = (src_req & src_en) | (pending & ~(clr | ack_clr | ~src_en));

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ack_q   <= 1'b0;
        end else begin
            pending <= pend_nxt;
            ack_q   <= ack;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            int_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state <= ASSERT;
                        cnt   <= PULSE_CNT;
                        int_n <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (!(|pending)) begin
                        state <= GAP;
                        cnt   <= GAP_CNT;
                        int_n <= 1'b1;
                    end else if (ack_rise) begin
                        state <= ACK;
                        int_n <= 1'b1;
                    end else if (zpos) begin
                        if (cnt <= 8'd1) begin
                            state <= GAP;
                            cnt   <= GAP_CNT;
                            int_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!ack) begin
                        state <= GAP;
                        cnt   <= GAP_CNT;
                    end
                end
                GAP: begin
                    if (zpos) begin
                        if (cnt <= 8'd1) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    int_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef ZINT_VECTOR_EN
    function automatic logic [7:0] vec_of(input logic [2:0] s);
        return VEC_BASE - {4'b0000, s, 1'b0};
    endfunction

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            vec    <= VEC_BASE;
            vec_oe <= 1'b0;
        end else if (ack_take) begin
            vec    <= vec_of(sel_nxt);
            vec_oe <= 1'b1;
        end else if (state == ACK) begin
            vec_oe <= ack;
        end else begin
            vec_oe <= 1'b0;
        end
    end
`else
    // IM1 build: the bus idles at FF whatever the base.
    assign vec    = VEC_BASE | 8'hFF;
    assign vec_oe = 1'b0;
`endif

endmodule
